// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: port identifiers and the read-return slot.
package dmem_arb_pkg;

   typedef logic port_id_t;

   localparam port_id_t PORT_CORE   = 1'b0;
   localparam port_id_t PORT_LOADER = 1'b1;

   localparam int RD_LAT_MAX = 4;

   typedef struct packed {
      logic     valid;
      port_id_t owner;
   } ret_slot_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester-side memory port: request/write bus in, grant and read return out.
interface dmem_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_ret_pipe.sv
// Read-return tracker: RD_LAT-deep shift register of {valid, owner} with synchronous clear.
module dmem_ret_pipe
   import dmem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic      clk,
   input  logic      rstn,
   input  ret_slot_t i_slot,
   output ret_slot_t o_slot
);

   ret_slot_t r_stage [RD_LAT];

   // NOTE: non-blocking assignments make every stage take its neighbour's pre-edge value.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_slot;
         for (int i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_slot = r_stage[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rstn,
   dmem_port_if.slave        m0,
   dmem_port_if.slave        m1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   logic              w_gnt_valid;
   port_id_t          w_gnt_id;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [ADDR_W-1:0] r_last_addr;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   ret_slot_t         w_slot_in;
   ret_slot_t         w_slot_out;
   logic              w_ret_live;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   always_comb begin
      w_gnt_valid = rstn && (m0.req || m1.req);
      w_gnt_id    = m0.req ? PORT_CORE : PORT_LOADER;
   end
`else
   port_id_t r_last_grant;

   // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      w_gnt_valid = rstn && (m0.req || m1.req);
      w_gnt_id    = m0.req ? PORT_CORE : PORT_LOADER;
      if (m0.req && m1.req) w_gnt_id = ~r_last_grant;
   end

   // Reset to the loader so the core wins the first conflict.
   always_ff @(posedge clk) begin
      if (!rstn)            r_last_grant <= PORT_LOADER;
      else if (w_gnt_valid) r_last_grant <= w_gnt_id;
   end
`endif

   assign m0.gnt = w_gnt_valid && (w_gnt_id == PORT_CORE);
   assign m1.gnt = w_gnt_valid && (w_gnt_id == PORT_LOADER);

   always_comb begin
      w_sel_we    = (w_gnt_id == PORT_CORE) ? m0.we    : m1.we;
      w_sel_addr  = (w_gnt_id == PORT_CORE) ? m0.addr  : m1.addr;
      w_sel_wdata = (w_gnt_id == PORT_CORE) ? m0.wdata : m1.wdata;
   end

   assign mem_we = w_gnt_valid && w_sel_we;
   assign mem_a  = w_gnt_valid ? w_sel_addr  : r_last_addr;
   assign mem_wd = w_gnt_valid ? w_sel_wdata : '0;

   always_ff @(posedge clk) begin
      if (!rstn)            r_last_addr <= '0;
      else if (w_gnt_valid) r_last_addr <= w_sel_addr;
   end

   // Only reads occupy a return slot; writes finish in the grant cycle.
   always_comb begin
      w_slot_in.valid = w_gnt_valid && !w_sel_we;
      w_slot_in.owner = w_gnt_id;
   end

   dmem_ret_pipe #(
      .RD_LAT (RD_LAT)
   ) u_ret_pipe (
      .clk    (clk),
      .rstn   (rstn),
      .i_slot (w_slot_in),
      .o_slot (w_slot_out)
   );

   // Gating with rstn drops a return that is still in the pipe when reset is first applied.
   assign w_ret_live = rstn && w_slot_out.valid;
   assign m0.rvalid  = w_ret_live && (w_slot_out.owner == PORT_CORE);
   assign m1.rvalid  = w_ret_live && (w_slot_out.owner == PORT_LOADER);
   assign m0.rdata   = m0.rvalid ? mem_rd : r_rdata0;
   assign m1.rdata   = m1.rvalid ? mem_rd : r_rdata1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (m0.rvalid) r_rdata0 <= mem_rd;
         if (m1.rvalid) r_rdata1 <= mem_rd;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: an RD_LAT=1 and an RD_LAT=3 instance share stimulus; a scoreboard tracks read returns.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic        port;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p0_a ();
   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p1_a ();
   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p0_b ();
   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p1_b ();

   assign p0_a.req = m0_req;  assign p0_a.we = m0_we;  assign p0_a.addr = m0_addr;  assign p0_a.wdata = m0_wdata;
   assign p1_a.req = m1_req;  assign p1_a.we = m1_we;  assign p1_a.addr = m1_addr;  assign p1_a.wdata = m1_wdata;
   assign p0_b.req = m0_req;  assign p0_b.we = m0_we;  assign p0_b.addr = m0_addr;  assign p0_b.wdata = m0_wdata;
   assign p1_b.req = m1_req;  assign p1_b.we = m1_we;  assign p1_b.addr = m1_addr;  assign p1_b.wdata = m1_wdata;

   logic        a_we, b_we;
   logic [31:0] a_a, a_wd, a_rd, b_a, b_wd, b_rd;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_a (
      .clk(clk), .rstn(rstn), .m0(p0_a), .m1(p1_a),
      .mem_we(a_we), .mem_a(a_a), .mem_wd(a_wd), .mem_rd(a_rd)
   );

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut_b (
      .clk(clk), .rstn(rstn), .m0(p0_b), .m1(p1_b),
      .mem_we(b_we), .mem_a(b_a), .mem_wd(b_wd), .mem_rd(b_rd)
   );

   function automatic logic [31:0] init_word(int i);
      return (i == 'h40) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
   endfunction

   // Memory models with registered read output, latency 1 and 3
   logic [31:0] mem_a_arr [256];
   logic [31:0] mem_b_arr [256];
   logic [31:0] ref_mem   [256];
   logic [31:0] rd_a_q;
   logic [31:0] rd_b_q [3];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a_arr[i] <= init_word(i);
         mem_b_arr[i] <= init_word(i);
         ref_mem[i]    = init_word(i);
      end
   end

   always @(posedge clk) begin
      if (a_we) mem_a_arr[a_a[9:2]] <= a_wd;
      rd_a_q <= mem_a_arr[a_a[9:2]];
   end
   assign a_rd = rd_a_q;

   always @(posedge clk) begin
      if (b_we) mem_b_arr[b_a[9:2]] <= b_wd;
      rd_b_q[0] <= mem_b_arr[b_a[9:2]];
      rd_b_q[1] <= rd_b_q[0];
      rd_b_q[2] <= rd_b_q[1];
   end
   assign b_rd = rd_b_q[2];

   logic        g0 [2], g1 [2], rv0 [2], rv1 [2], we_v [2];
   logic [31:0] rd0 [2], rd1 [2], ma [2], mwd [2];
   assign g0[0] = p0_a.gnt;     assign g0[1] = p0_b.gnt;
   assign g1[0] = p1_a.gnt;     assign g1[1] = p1_b.gnt;
   assign rv0[0] = p0_a.rvalid; assign rv0[1] = p0_b.rvalid;
   assign rv1[0] = p1_a.rvalid; assign rv1[1] = p1_b.rvalid;
   assign rd0[0] = p0_a.rdata;  assign rd0[1] = p0_b.rdata;
   assign rd1[0] = p1_a.rdata;  assign rd1[1] = p1_b.rdata;
   assign we_v[0] = a_we;       assign we_v[1] = b_we;
   assign ma[0] = a_a;          assign ma[1] = b_a;
   assign mwd[0] = a_wd;        assign mwd[1] = b_wd;

   // Scoreboard: expected grants from a reference arbiter, read returns queued per instance
   exp_t        q_a[$];
   exp_t        q_b[$];
   logic        ref_last = 1'b1;
   logic [31:0] last_addr = '0;
   logic [31:0] hold [2][2];
   logic        rst_seen = 1'b0;

   always @(negedge clk) begin
      logic        eg_v, eg_p, eg_we, have, ok;
      logic [31:0] eg_addr, eg_wd;
      exp_t        e;
      cyc++;
      if (!rstn) begin
         q_a.delete();
         q_b.delete();
         ref_last  = 1'b1;
         last_addr = '0;
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({g0[k], g1[k], rv0[k], rv1[k], we_v[k]} !== 5'b0) begin
               n_bad++;
               $display("FAIL reset_outputs inst%0d cyc%0d: gnt=%b%b rvalid=%b%b mem_we=%b, want all 0",
                        k, cyc, g0[k], g1[k], rv0[k], rv1[k], we_v[k]);
            end
            if (rst_seen) begin
               n_cmp++;
               if (rd0[k] !== '0 || rd1[k] !== '0 || ma[k] !== '0) begin
                  n_bad++;
                  $display("FAIL reset_regs inst%0d cyc%0d: rdata0=%h rdata1=%h mem_a=%h, want 0",
                           k, cyc, rd0[k], rd1[k], ma[k]);
               end
            end
            hold[k][0] = '0;
            hold[k][1] = '0;
         end
         rst_seen = 1'b1;
      end else begin
         rst_seen = 1'b0;
         eg_v = m0_req || m1_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
         eg_p = !m0_req;
`else
         eg_p = (m0_req && m1_req) ? !ref_last : !m0_req;
`endif
         eg_we   = eg_p ? m1_we    : m0_we;
         eg_addr = eg_p ? m1_addr  : m0_addr;
         eg_wd   = eg_p ? m1_wdata : m0_wdata;
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (g0[k] !== (eg_v && !eg_p) || g1[k] !== (eg_v && eg_p)) begin
               n_bad++;
               $display("FAIL gnt inst%0d cyc%0d: got %b%b want %b%b",
                        k, cyc, g0[k], g1[k], eg_v && !eg_p, eg_v && eg_p);
            end
            n_cmp++;
            if (we_v[k] !== (eg_v && eg_we)) begin
               n_bad++;
               $display("FAIL mem_we inst%0d cyc%0d: got %b want %b", k, cyc, we_v[k], eg_v && eg_we);
            end
            n_cmp++;
            ok = eg_v ? (ma[k] === eg_addr && mwd[k] === eg_wd) : (ma[k] === last_addr && mwd[k] === '0);
            if (!ok) begin
               n_bad++;
               $display("FAIL mem_bus inst%0d cyc%0d: got a=%h wd=%h want a=%h wd=%h", k, cyc, ma[k], mwd[k],
                        eg_v ? eg_addr : last_addr, eg_v ? eg_wd : 32'h0);
            end
         end
         if (eg_v) begin
            ref_last  = eg_p;
            last_addr = eg_addr;
            if (eg_we) begin
               ref_mem[eg_addr[9:2]] = eg_wd;
            end else begin
               q_a.push_back('{port: eg_p, data: ref_mem[eg_addr[9:2]], due: cyc + 1});
               q_b.push_back('{port: eg_p, data: ref_mem[eg_addr[9:2]], due: cyc + 3});
            end
         end
         for (int k = 0; k < 2; k++) begin
            have = 1'b0;
            e    = '{port: 1'b0, data: '0, due: 0};
            if (k == 0 && q_a.size() > 0 && q_a[0].due == cyc) begin
               have = 1'b1;
               e    = q_a.pop_front();
            end
            if (k == 1 && q_b.size() > 0 && q_b[0].due == cyc) begin
               have = 1'b1;
               e    = q_b.pop_front();
            end
            if (have) hold[k][e.port] = e.data;
            n_cmp++;
            if (rv0[k] !== (have && !e.port) || rv1[k] !== (have && e.port)) begin
               n_bad++;
               $display("FAIL rvalid inst%0d cyc%0d: got %b%b want %b%b",
                        k, cyc, rv0[k], rv1[k], have && !e.port, have && e.port);
            end
            n_cmp++;
            if (rd0[k] !== hold[k][0] || rd1[k] !== hold[k][1]) begin
               n_bad++;
               $display("FAIL rdata inst%0d cyc%0d: got %h/%h want %h/%h",
                        k, cyc, rd0[k], rd1[k], hold[k][0], hold[k][1]);
            end
         end
      end
   end

   task automatic idle_inputs();
      m0_req = 1'b0; m0_we = 1'b0;
      m1_req = 1'b0; m1_we = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      idle_inputs();
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic drain();
      int n;
      idle_inputs();
      n = 0;
      while ((q_a.size() > 0 || q_b.size() > 0) && n < 20) begin
         @(posedge clk);
         n++;
      end
      n_cmp++;
      if (q_a.size() > 0 || q_b.size() > 0) begin
         n_bad++;
         $display("FAIL drain_timeout: pending a=%0d b=%0d want 0/0", q_a.size(), q_b.size());
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rstn = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40;
      m1_req = 1'b1; m1_we = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (p0_a.gnt !== 1'b0 || p1_a.gnt !== 1'b0 || a_we !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_gnt: gnt=%b%b mem_we=%b want 000", p0_a.gnt, p1_a.gnt, a_we);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (p0_a.rdata !== '0 || p1_b.rdata !== '0 || p0_b.rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rdata: rdata=%h/%h rvalid=%b want 0", p0_a.rdata, p1_b.rdata, p0_b.rvalid);
      end
      @(posedge clk); #1;
      idle_inputs();
      rstn = 1'b1;
   endtask

   task automatic test_single_read();
      @(posedge clk); #1;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
      @(negedge clk);
      n_cmp++;
      if (p0_a.gnt !== 1'b1) begin
         n_bad++;
         $display("FAIL single_gnt: m0_gnt=%b want 1", p0_a.gnt);
      end
      @(posedge clk); #1;
      m0_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (p0_a.rvalid !== 1'b1 || p0_a.rdata !== 32'hDEADBEEF || p1_a.rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_ret: rvalid=%b rdata=%h m1_rvalid=%b want 1 deadbeef 0",
                  p0_a.rvalid, p0_a.rdata, p1_a.rvalid);
      end
      drain();
   endtask

   task automatic test_conflict();
      logic e, prev_e;
      apply_reset();
      m0_addr = 32'h000;
      m1_addr = 32'h080;
      prev_e  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i > 0) begin
            if (prev_e) m1_addr = m1_addr + 4;
            else        m0_addr = m0_addr + 4;
         end
         m0_req = (i < 4);
         m1_req = (i < 4);
`ifdef DMEM_ARB_FIXED_PRIO_EN
         if (i == 3) m0_req = 1'b0;
         e = (i == 3);
`else
         e = i[0];
`endif
         @(negedge clk);
         if (i < 4) begin
            n_cmp++;
            if (p0_a.gnt !== !e || p1_a.gnt !== e) begin
               n_bad++;
               $display("FAIL conflict_gnt i%0d: got %b%b want %b%b", i, p0_a.gnt, p1_a.gnt, !e, e);
            end
         end
         if (i > 0) begin
            n_cmp++;
            if (p0_a.rvalid !== !prev_e || p1_a.rvalid !== prev_e) begin
               n_bad++;
               $display("FAIL conflict_rv i%0d: got %b%b want %b%b", i, p0_a.rvalid, p1_a.rvalid, !prev_e, prev_e);
            end
         end
         prev_e = e;
      end
      drain();
   endtask

   task automatic test_write_read();
      int we_cnt, m1_rv;
      we_cnt = 0;
      m1_rv  = 0;
      @(posedge clk); #1;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h12345678;
      @(negedge clk);
      we_cnt += int'(a_we);
      @(posedge clk); #1;
      m1_req = 1'b0; m1_we = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
      @(negedge clk);
      we_cnt += int'(a_we);
      @(posedge clk); #1;
      m0_req = 1'b0;
      @(negedge clk);
      we_cnt += int'(a_we);
      m1_rv  += int'(p1_a.rvalid);
      n_cmp++;
      if (p0_a.rvalid !== 1'b1 || p0_a.rdata !== 32'h12345678) begin
         n_bad++;
         $display("FAIL wr_rd_data: rvalid=%b rdata=%h want 1 12345678", p0_a.rvalid, p0_a.rdata);
      end
      repeat (3) begin
         @(negedge clk);
         we_cnt += int'(a_we);
         m1_rv  += int'(p1_a.rvalid);
      end
      n_cmp++;
      if (we_cnt != 1 || m1_rv != 0) begin
         n_bad++;
         $display("FAIL wr_rd_pulses: mem_we=%0d m1_rvalid=%0d want 1 and 0", we_cnt, m1_rv);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int n_ret;
      n_ret = 0;
      for (int t = 0; t < 9; t++) begin
         @(posedge clk); #1;
         m0_req  = (t < 3);
         m0_we   = 1'b0;
         m0_addr = 32'h104 + 32'(4 * t);
         @(negedge clk);
         if (p0_b.rvalid) begin
            n_cmp++;
            if (t < 3 || t > 5 || p0_b.rdata !== init_word('h41 + t - 3)) begin
               n_bad++;
               $display("FAIL b2b_ret t%0d: rdata=%h, want return only at t3..5 with %h",
                        t, p0_b.rdata, init_word('h41 + t - 3));
            end
            n_ret++;
         end
      end
      n_cmp++;
      if (n_ret != 3) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d returns want 3", n_ret);
      end
      drain();
   endtask

   task automatic test_reset_mid_read();
      int n_rv;
      n_rv = 0;
      @(posedge clk); #1;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h104;
      @(negedge clk);
      n_cmp++;
      if (p0_a.gnt !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_gnt: m0_gnt=%b want 1", p0_a.gnt);
      end
      @(posedge clk); #1;
      m0_req = 1'b0;
      m1_req = 1'b1;
      rstn   = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (p0_a.rvalid !== 1'b0 || p1_a.gnt !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_out: rvalid=%b m1_gnt=%b want 0 0", p0_a.rvalid, p1_a.gnt);
      end
      @(posedge clk); #1;
      rstn   = 1'b1;
      m1_req = 1'b0;
      repeat (6) begin
         @(negedge clk);
         n_rv += int'(p0_a.rvalid) + int'(p0_b.rvalid);
      end
      n_cmp++;
      if (n_rv != 0) begin
         n_bad++;
         $display("FAIL midrst_rvalid: got %0d rvalid cycles want 0", n_rv);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_conflict();
      test_write_read();
      test_back_to_back();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
